// File: rtl/xadc_pkg.sv
// Shared constants and types for the XADC DRP read sequencer.
// Channel order matches the joystick pipeline: VAUX3, VAUX10, VAUX2, VAUX11.
package xadc_pkg;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned DRP_W    = 16;

  // Packed so ADDR[i] yields the DRP status-register address of channel i.
  localparam logic [NUM_CH-1:0][ADDR_W-1:0] ADDR = {7'h1B, 7'h12, 7'h1A, 7'h13};

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_e;

  typedef logic [$clog2(NUM_CH)-1:0] ch_idx_t;

  // XADC results are left-justified in the 16-bit status register.
  function automatic logic [SAMPLE_W-1:0] drp_sample(input logic [DRP_W-1:0] d);
    return d[DRP_W-1 -: SAMPLE_W];
  endfunction

endpackage

// File: rtl/xadc_drp_sequencer.sv
// Reads the four joystick XADC channels over DRP once per end-of-conversion,
// with a per-read drdy timeout so a hung DRP cannot stall the frame forever.
module xadc_drp_sequencer
  import xadc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                eoc,
  input  logic                drdy,
  input  logic [DRP_W-1:0]    do_drp,
  output logic                den,
  output logic                dwe,
  output logic [DRP_W-1:0]    di,
  output logic [ADDR_W-1:0]   daddr,
  output logic [SAMPLE_W-1:0] adc0_out,
  output logic [SAMPLE_W-1:0] adc1_out,
  output logic [SAMPLE_W-1:0] adc2_out,
  output logic [SAMPLE_W-1:0] adc3_out,
  output logic [NUM_CH-1:0]   sample_valid,
  output logic                frame_done,
  output logic                timeout_err,
  output logic                busy
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam ch_idx_t LAST_CH = ch_idx_t'(NUM_CH - 1);

  state_e                           state_q, state_d;
  ch_idx_t                          idx_q, idx_d;
  logic [TW-1:0]                    timer_q, timer_d;
  logic                             pending_q, pending_d;
  logic                             busy_q, busy_d;
  logic                             den_q, den_d;
  logic [ADDR_W-1:0]                daddr_q, daddr_d;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]  adc_q, adc_d;
  logic [NUM_CH-1:0]                valid_q, valid_d;
  logic                             frame_done_q, frame_done_d;
  logic                             timeout_q, timeout_d;

  // Status bits in the low nibble carry nothing the joystick path needs.
  logic unused_drp_status;
  assign unused_drp_status = ^do_drp[3:0];

  // Timer is zeroed during the den cycle, so expiry lands TIMEOUT cycles after den.
  logic timer_expired;
  assign timer_expired = (timer_q == TIMER_LAST);

  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise paths
    // that skip an assignment would infer a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    pending_d    = pending_q;
    busy_d       = busy_q;
    den_d        = 1'b0;
    daddr_d      = daddr_q;
    adc_d        = adc_q;
    valid_d      = '0;
    frame_done_d = 1'b0;
    timeout_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (eoc || pending_q) begin
          state_d   = REQ;
          idx_d     = '0;
          den_d     = 1'b1;
          daddr_d   = ADDR[0];
          timer_d   = '0;
          busy_d    = 1'b1;
          pending_d = 1'b0;
        end
      end

      REQ: begin
        state_d = WAIT;
        timer_d = timer_q + TW'(1);
        if (eoc) pending_d = 1'b1;
      end

      WAIT: begin
        timer_d = timer_q + TW'(1);
        if (eoc) pending_d = 1'b1;

        // drdy takes priority over a coincident timer expiry.
        if (drdy) begin
          adc_d[idx_q]   = drp_sample(do_drp);
          valid_d[idx_q] = 1'b1;
        end else if (timer_expired) begin
          timeout_d = 1'b1;
        end

        if (drdy || timer_expired) begin
          if (idx_q == LAST_CH) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
          end else begin
            state_d = REQ;
            idx_d   = idx_q + ch_idx_t'(1);
            den_d   = 1'b1;
            daddr_d = ADDR[idx_q + ch_idx_t'(1)];
            timer_d = '0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      timer_q      <= '0;
      pending_q    <= 1'b0;
      busy_q       <= 1'b0;
      den_q        <= 1'b0;
      daddr_q      <= '0;
      // NOTE: the sample registers are reset too; downstream scaling must see
      // zero rather than stale data after a reset.
      adc_q        <= '0;
      valid_q      <= '0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      pending_q    <= pending_d;
      busy_q       <= busy_d;
      den_q        <= den_d;
      daddr_q      <= daddr_d;
      adc_q        <= adc_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign den          = den_q;
  assign dwe          = 1'b0;
  assign di           = '0;
  assign daddr        = daddr_q;
  assign adc0_out     = adc_q[0];
  assign adc1_out     = adc_q[1];
  assign adc2_out     = adc_q[2];
  assign adc3_out     = adc_q[3];
  assign sample_valid = valid_q;
  assign frame_done   = frame_done_q;
  assign timeout_err  = timeout_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Self-checking bench: a procedural frame model predicts every output each
// cycle, while literal checks pin the headline scenarios.
module tb_xadc_drp_sequencer;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        eoc;
  logic        drdy;
  logic [15:0] do_drp;
  logic        den, dwe, frame_done, timeout_err, busy;
  logic [15:0] di;
  logic [6:0]  daddr;
  logic [11:0] adc0_out, adc1_out, adc2_out, adc3_out;
  logic [3:0]  sample_valid;

  always #5 clk = ~clk;

  xadc_drp_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .eoc(eoc), .drdy(drdy), .do_drp(do_drp),
    .den(den), .dwe(dwe), .di(di), .daddr(daddr),
    .adc0_out(adc0_out), .adc1_out(adc1_out), .adc2_out(adc2_out), .adc3_out(adc3_out),
    .sample_valid(sample_valid), .frame_done(frame_done),
    .timeout_err(timeout_err), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ch_addr(input int ch);
    case (ch)
      0: return 7'h13;
      1: return 7'h1A;
      2: return 7'h12;
      default: return 7'h1B;
    endcase
  endfunction

  function automatic int addr_ch(input logic [6:0] a);
    for (int i = 0; i < 4; i++) if (ch_addr(i) == a) return i;
    return -1;
  endfunction

  // ---------------- DRP responder ----------------
  int          resp_delay [4];
  logic [15:0] resp_data  [4];
  int          man_req = 0;
  logic [15:0] man_data;

  initial begin : responder
    int cnt = 0;
    int man_ack = 0;
    logic [15:0] pend;
    drdy = 1'b0;
    do_drp = 16'h0;
    pend = 16'h0;
    forever begin
      @(negedge clk);
      drdy = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          drdy = 1'b1;
          do_drp = pend;
        end
      end
      if (man_req != man_ack) begin
        man_ack = man_req;
        drdy = 1'b1;
        do_drp = man_data;
      end
      if (den && addr_ch(daddr) >= 0 && resp_delay[addr_ch(daddr)] > 0) begin
        cnt = resp_delay[addr_ch(daddr)];
        pend = resp_data[addr_ch(daddr)];
      end
    end
  end

  // ---------------- Behavioural model ----------------
  logic        e_den;
  logic [6:0]  e_daddr;
  logic [11:0] e_adc [4];
  logic [3:0]  e_valid;
  logic        e_fd, e_to, e_busy;
  bit          m_pending, m_abort;

  task automatic model_reset();
    e_den = 1'b0; e_daddr = 7'h0; e_valid = 4'h0;
    e_fd = 1'b0; e_to = 1'b0; e_busy = 1'b0; m_pending = 1'b0;
    for (int i = 0; i < 4; i++) e_adc[i] = 12'h0;
  endtask

  task automatic model_step();
    @(posedge clk);
    e_den = 1'b0; e_valid = 4'h0; e_fd = 1'b0; e_to = 1'b0;
    if (reset) begin
      model_reset();
      m_abort = 1'b1;
    end else if (eoc) begin
      m_pending = 1'b1;
    end
  endtask

  // One frame: for each channel a den cycle, then up to TO-1 cycles of waiting.
  task automatic model_frame();
    bit got;
    e_busy = 1'b1;
    m_pending = 1'b0;
    for (int ch = 0; ch < 4; ch++) begin
      e_den = 1'b1;
      e_daddr = ch_addr(ch);
      model_step();
      if (m_abort) return;
      got = 1'b0;
      for (int w = 1; w < TO && !got; w++) begin
        model_step();
        if (m_abort) return;
        if (drdy) begin
          e_adc[ch] = do_drp[15:4];
          e_valid[ch] = 1'b1;
          got = 1'b1;
        end
      end
      if (!got) e_to = 1'b1;
    end
    e_fd = 1'b1;
    e_busy = 1'b0;
  endtask

  initial begin : model
    model_reset();
    forever begin
      @(posedge clk);
      e_den = 1'b0; e_valid = 4'h0; e_fd = 1'b0; e_to = 1'b0;
      if (reset) model_reset();
      else if (eoc || m_pending) begin
        m_abort = 1'b0;
        model_frame();
      end
    end
  end

  // ---------------- Compare + event log ----------------
  int         cyc = 0;
  int         n_fd = 0, n_to = 0, n_valid = 0;
  int         den1_cyc = 0, to_cyc = 0;
  logic [6:0] addr_log [$];
  int         valid_log [$];

  initial begin : compare
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      check("ctrl", {den, dwe, daddr, sample_valid, frame_done, timeout_err, busy},
                    {e_den, 1'b0, e_daddr, e_valid, e_fd, e_to, e_busy});
      check("di", di, 16'h0);
      check("adc", {adc3_out, adc2_out, adc1_out, adc0_out},
                   {e_adc[3], e_adc[2], e_adc[1], e_adc[0]});
      if (den) addr_log.push_back(daddr);
      if (den && daddr == 7'h1A) den1_cyc = cyc;
      for (int i = 0; i < 4; i++) if (sample_valid[i]) begin
        valid_log.push_back(i);
        n_valid++;
      end
      if (frame_done) n_fd++;
      if (timeout_err) begin
        n_to++;
        to_cyc = cyc;
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic set_resp(input int d0, d1, d2, d3,
                          input logic [15:0] x0, x1, x2, x3);
    resp_delay[0] = d0; resp_delay[1] = d1; resp_delay[2] = d2; resp_delay[3] = d3;
    resp_data[0] = x0;  resp_data[1] = x1;  resp_data[2] = x2;  resp_data[3] = x3;
  endtask

  task automatic pulse_eoc();
    @(negedge clk); eoc = 1'b1;
    @(negedge clk); eoc = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int budget, input string name);
    for (int i = 0; i < budget && n_fd < target; i++) @(negedge clk);
    check(name, n_fd >= target, 1'b1);
  endtask

  initial begin : main
    int base_a, base_v, base_fd, base_to, base_nv;
    reset = 1'b1;
    eoc = 1'b0;
    man_data = 16'h0;
    set_resp(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    check("rst_ctrl", {den, daddr, sample_valid, frame_done, timeout_err, busy}, 0);
    check("rst_adc", {adc3_out, adc2_out, adc1_out, adc0_out}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame, DRP answers 2 cycles after each den.
    set_resp(2, 2, 2, 2, 16'hABC0, 16'h1230, 16'hFFF0, 16'h0010);
    base_a = addr_log.size(); base_v = valid_log.size(); base_fd = n_fd;
    pulse_eoc();
    wait_fd(base_fd + 1, 100, "t1_frame_done");
    repeat (5) @(negedge clk);
    check("t1_adc0", adc0_out, 12'hABC);
    check("t1_adc1", adc1_out, 12'h123);
    check("t1_adc2", adc2_out, 12'hFFF);
    check("t1_adc3", adc3_out, 12'h001);
    check("t1_naddr", addr_log.size() - base_a, 4);
    check("t1_nvalid", valid_log.size() - base_v, 4);
    for (int i = 0; i < 4 && base_a + i < addr_log.size(); i++)
      check("t1_daddr", addr_log[base_a + i], ch_addr(i));
    for (int i = 0; i < 4 && base_v + i < valid_log.size(); i++)
      check("t1_valid_order", valid_log[base_v + i], i);
    check("t1_nframes", n_fd - base_fd, 1);

    // Channel 1 never answers.
    set_resp(2, 0, 2, 2, 16'h1110, 16'h5550, 16'h2220, 16'h3330);
    base_fd = n_fd; base_to = n_to;
    pulse_eoc();
    wait_fd(base_fd + 1, 300, "t2_frame_done");
    repeat (3) @(negedge clk);
    check("t2_ntimeout", n_to - base_to, 1);
    check("t2_timeout_gap", to_cyc - den1_cyc, 64);
    check("t2_adc0", adc0_out, 12'h111);
    check("t2_adc1_held", adc1_out, 12'h123);
    check("t2_adc2", adc2_out, 12'h222);
    check("t2_adc3", adc3_out, 12'h333);

    // drdy on the very cycle the timer expires: data wins.
    set_resp(1, 63, 1, 1, 16'h0A10, 16'h4560, 16'h0B20, 16'h0C30);
    base_fd = n_fd; base_to = n_to; base_nv = n_valid;
    pulse_eoc();
    wait_fd(base_fd + 1, 300, "t6_frame_done");
    repeat (3) @(negedge clk);
    check("t6_ntimeout", n_to - base_to, 0);
    check("t6_adc1", adc1_out, 12'h456);
    check("t6_nvalid", n_valid - base_nv, 4);

    // Three eocs during a busy frame collapse into one extra frame.
    set_resp(5, 5, 5, 5, 16'hC0D0, 16'h0E10, 16'h7FF0, 16'h8000);
    base_fd = n_fd;
    pulse_eoc();
    repeat (2) @(negedge clk);
    pulse_eoc();
    repeat (2) @(negedge clk);
    pulse_eoc();
    repeat (2) @(negedge clk);
    pulse_eoc();
    wait_fd(base_fd + 2, 300, "t3_two_frames");
    repeat (40) @(negedge clk);
    check("t3_nframes", n_fd - base_fd, 2);
    check("t3_busy", busy, 1'b0);

    // drdy while idle is ignored.
    base_nv = n_valid;
    man_data = 16'hFFF0;
    man_req++;
    repeat (4) @(negedge clk);
    check("t4_adc", {adc3_out, adc2_out, adc1_out, adc0_out}, 48'h800_7FF_0E1_C0D);
    check("t4_nvalid", n_valid - base_nv, 0);

    // Reset while waiting on channel 2, then a late drdy.
    set_resp(1, 1, 0, 1, 16'h1000, 16'h2000, 16'h3000, 16'h4000);
    base_a = addr_log.size();
    pulse_eoc();
    for (int i = 0; i < 50 && addr_log.size() < base_a + 3; i++) @(negedge clk);
    check("t5_reached_ch2", addr_log.size() - base_a, 3);
    repeat (4) @(negedge clk);
    check("t5_busy_before", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_ctrl", {den, daddr, sample_valid, frame_done, timeout_err, busy}, 0);
    check("t5_rst_adc", {adc3_out, adc2_out, adc1_out, adc0_out}, 0);
    reset = 1'b0;
    base_nv = n_valid;
    man_data = 16'h7770;
    man_req++;
    repeat (4) @(negedge clk);
    check("t5_late_drdy_adc", {adc3_out, adc2_out, adc1_out, adc0_out}, 0);
    check("t5_late_drdy_valid", n_valid - base_nv, 0);
    check("t5_idle_busy", busy, 1'b0);
    set_resp(1, 1, 1, 1, 16'h0120, 16'h0340, 16'h0560, 16'h0780);
    base_a = addr_log.size(); base_fd = n_fd;
    pulse_eoc();
    wait_fd(base_fd + 1, 100, "t5_restart_frame");
    check("t5_restart_addr", addr_log.size() > base_a ? addr_log[base_a] : 7'h0, 7'h13);
    repeat (3) @(negedge clk);
    check("t5_adc", {adc3_out, adc2_out, adc1_out, adc0_out}, 48'h078_056_034_012);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish actual=running expected=done");
    $fatal(1, "watchdog expired");
  end

endmodule
